// File: rtl/axi_burst_master_if.sv
// AXI4 full-interface bundle between the burst master and a memory slave.
interface axi_burst_master_if #(
  parameter int ID_WIDTH   = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ID_WIDTH-1:0]     AWID;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWVALID;
  logic                    AWREADY;

  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;

  logic [ID_WIDTH-1:0]     BID;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;

  logic [ID_WIDTH-1:0]     ARID;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [7:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic                    ARVALID;
  logic                    ARREADY;

  logic [ID_WIDTH-1:0]     RID;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RLAST;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output WDATA, WSTRB, WLAST, WVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output RREADY,
    input  AWREADY, WREADY, BID, BRESP, BVALID, ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  WDATA, WSTRB, WLAST, WVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  RREADY,
    output AWREADY, WREADY, BID, BRESP, BVALID, ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_burst_master.sv
// Writes one INCR burst of seeded data over the whole slave, reads it back and counts bad beats.
// AWVALID one cycle after an accepted start; every channel waits on its handshake, outputs decode from state only.
module axi_burst_master #(
  parameter int C_M_AXI_ID_WIDTH   = 2,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 5,
  parameter bit OPT_LOWPOWER       = 1'b0
) (
  input  logic                          M_AXI_CLK,
  input  logic                          M_AXI_RST,
  input  logic                          i_start,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] i_seed,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_error,
  output logic [C_M_AXI_ADDR_WIDTH-$clog2(C_M_AXI_DATA_WIDTH/8):0] o_err_cnt,
  axi_burst_master_if.master            M_AXI
);
  localparam int DW      = C_M_AXI_DATA_WIDTH;
  localparam int IW      = C_M_AXI_ID_WIDTH;
  localparam int SIZE    = $clog2(DW/8);
  localparam int CNTR_WD = C_M_AXI_ADDR_WIDTH - SIZE;
  localparam int BEATS   = 1 << CNTR_WD;

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [CNTR_WD-1:0] cnt;
  logic [DW-1:0]      seed_q;
  logic [DW-1:0]      pattern;
  logic [IW-1:0]      awid, arid;
  logic               last_beat, beat_bad;
  logic               aw_vld, w_vld, b_rdy, ar_vld, r_rdy;

  assign last_beat = (cnt == {CNTR_WD{1'b1}});
  assign pattern   = DW'(cnt) ^ seed_q;
  assign beat_bad  = (M_AXI.RRESP != 2'b00) || (M_AXI.RID != arid) ||
                     (M_AXI.RDATA != pattern) || (M_AXI.RLAST != last_beat);

  always_comb begin
    state_nxt = state;
    aw_vld    = 1'b0;
    w_vld     = 1'b0;
    b_rdy     = 1'b0;
    ar_vld    = 1'b0;
    r_rdy     = 1'b0;
    o_done    = 1'b0;
    case (state)
      S_IDLE: if (i_start) state_nxt = S_AW;
      S_AW: begin
        aw_vld = 1'b1;
        if (M_AXI.AWREADY) state_nxt = S_W;
      end
      S_W: begin
        w_vld = 1'b1;
        if (M_AXI.WREADY && last_beat) state_nxt = S_B;
      end
      S_B: begin
        b_rdy = 1'b1;
        if (M_AXI.BVALID) state_nxt = S_AR;
      end
      S_AR: begin
        ar_vld = 1'b1;
        if (M_AXI.ARREADY) state_nxt = S_R;
      end
      S_R: begin
        r_rdy = 1'b1;
        if (M_AXI.RVALID && last_beat) state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_CLK) begin
    if (M_AXI_RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      seed_q    <= '0;
      awid      <= '0;
      arid      <= '0;
      o_error   <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (i_start) begin
          seed_q    <= i_seed;
          o_error   <= 1'b0;
          o_err_cnt <= '0;
          cnt       <= '0;
        end
        S_W: if (M_AXI.WREADY) cnt <= cnt + 1'b1;
        S_B: if (M_AXI.BVALID) begin
          if (M_AXI.BRESP != 2'b00 || M_AXI.BID != awid) o_error <= 1'b1;
          awid <= awid + 1'b1;
        end
        S_AR: if (M_AXI.ARREADY) cnt <= '0;
        S_R: if (M_AXI.RVALID) begin
          cnt <= cnt + 1'b1;
          if (beat_bad) begin
            o_error <= 1'b1;
            if (!(&o_err_cnt)) o_err_cnt <= o_err_cnt + 1'b1;
          end
          if (last_beat) arid <= arid + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (state != S_IDLE);

  // Address, length and burst shape are fixed: one burst spans the whole slave.
  assign M_AXI.AWID    = awid;
  assign M_AXI.AWADDR  = '0;
  assign M_AXI.AWLEN   = 8'(BEATS - 1);
  assign M_AXI.AWSIZE  = 3'(SIZE);
  assign M_AXI.AWBURST = 2'b01;
  assign M_AXI.AWVALID = aw_vld;

  assign M_AXI.WDATA   = (OPT_LOWPOWER && !w_vld) ? '0 : pattern;
  assign M_AXI.WSTRB   = '1;
  assign M_AXI.WLAST   = w_vld && last_beat;
  assign M_AXI.WVALID  = w_vld;

  assign M_AXI.BREADY  = b_rdy;

  assign M_AXI.ARID    = arid;
  assign M_AXI.ARADDR  = '0;
  assign M_AXI.ARLEN   = 8'(BEATS - 1);
  assign M_AXI.ARSIZE  = 3'(SIZE);
  assign M_AXI.ARBURST = 2'b01;
  assign M_AXI.ARVALID = ar_vld;

  assign M_AXI.RREADY  = r_rdy;
endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: memory slave with optional backpressure and fault injection,
// queued expectations popped by a monitor on every AW/W/AR handshake and every done pulse.
module tb_axi_burst_master;
  localparam int IDW   = 2;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int BEATS = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] seed = '0;
  logic          busy, done, error;
  logic [3:0]    err_cnt;

  always #5 clk = ~clk;

  axi_burst_master_if #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axi_burst_master #(
    .C_M_AXI_ID_WIDTH(IDW), .C_M_AXI_DATA_WIDTH(DW),
    .C_M_AXI_ADDR_WIDTH(AW), .OPT_LOWPOWER(1'b0)
  ) dut (
    .M_AXI_CLK(clk), .M_AXI_RST(rst), .i_start(start), .i_seed(seed),
    .o_busy(busy), .o_done(done), .o_error(error), .o_err_cnt(err_cnt),
    .M_AXI(bus.master)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model state and scoreboard queues
  logic [IDW-1:0] next_id = '0;
  logic [DW:0]    exp_w[$];
  logic [IDW-1:0] exp_awid[$];
  logic [IDW-1:0] exp_arid[$];
  logic [4:0]     exp_res[$];
  int             done_cnt = 0;

  // Slave configuration and state
  bit             bp = 1'b0;
  logic [7:0]     corrupt_mask = '0;
  logic [7:0]     rerr_mask = '0;
  logic [DW-1:0]  mem [BEATS];
  int             w_idx, r_idx, b_delay;
  bit             b_pend, r_act;
  logic [IDW-1:0] b_id_q, r_id_q;

  bit             aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [IDW-1:0] awid_c, arid_c;
  logic [DW-1:0]  wdata_c;
  logic           wlast_c;
  bit             aw_stall, w_stall, ar_stall;
  logic [IDW-1:0] aw_prev, ar_prev;
  logic [DW:0]    w_prev;

  initial begin
    logic [DW:0]    ew;
    logic [IDW-1:0] eid;
    logic [4:0]     er;
    bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.BID = '0; bus.BRESP = '0;
    bus.ARREADY = 0; bus.RVALID = 0; bus.RID = '0; bus.RDATA = '0; bus.RRESP = '0; bus.RLAST = 0;
    w_idx = 0; r_idx = 0; b_delay = 0; b_pend = 0; r_act = 0; b_id_q = '0; r_id_q = '0;
    aw_stall = 0; w_stall = 0; ar_stall = 0;
    forever begin
      @(negedge clk);
      aw_hs = bus.AWVALID && bus.AWREADY;  awid_c = bus.AWID;
      w_hs  = bus.WVALID && bus.WREADY;    wdata_c = bus.WDATA; wlast_c = bus.WLAST;
      b_hs  = bus.BVALID && bus.BREADY;
      ar_hs = bus.ARVALID && bus.ARREADY;  arid_c = bus.ARID;
      r_hs  = bus.RVALID && bus.RREADY;
      if (!rst) begin
        if (aw_stall) check("aw_hold", {bus.AWVALID, bus.AWID}, {1'b1, aw_prev});
        if (w_stall)  check("w_hold", {bus.WVALID, bus.WLAST, bus.WDATA}, {1'b1, w_prev});
        if (ar_stall) check("ar_hold", {bus.ARVALID, bus.ARID}, {1'b1, ar_prev});
        if (aw_hs) begin
          eid = (exp_awid.size() != 0) ? exp_awid.pop_front() : 'x;
          check("aw_id", awid_c, eid);
          check("aw_fields", {bus.AWADDR, bus.AWLEN, bus.AWSIZE, bus.AWBURST},
                {5'd0, 8'd7, 3'd2, 2'd1});
        end
        if (w_hs) begin
          ew = (exp_w.size() != 0) ? exp_w.pop_front() : 'x;
          check("w_beat", {wlast_c, wdata_c}, ew);
          check("w_strb", bus.WSTRB, 4'hF);
        end
        if (ar_hs) begin
          eid = (exp_arid.size() != 0) ? exp_arid.pop_front() : 'x;
          check("ar_id", arid_c, eid);
          check("ar_fields", {bus.ARADDR, bus.ARLEN, bus.ARSIZE, bus.ARBURST},
                {5'd0, 8'd7, 3'd2, 2'd1});
        end
        if (done) begin
          done_cnt++;
          er = (exp_res.size() != 0) ? exp_res.pop_front() : 'x;
          check("result", {error, err_cnt}, er);
        end
        aw_stall = bus.AWVALID && !bus.AWREADY; aw_prev = bus.AWID;
        w_stall  = bus.WVALID && !bus.WREADY;   w_prev  = {bus.WLAST, bus.WDATA};
        ar_stall = bus.ARVALID && !bus.ARREADY; ar_prev = bus.ARID;
      end else begin
        aw_stall = 0; w_stall = 0; ar_stall = 0;
      end

      @(posedge clk); #1;
      if (rst) begin
        bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.ARREADY = 0; bus.RVALID = 0;
        bus.RLAST = 0; w_idx = 0; r_idx = 0; b_pend = 0; r_act = 0;
      end else begin
        if (aw_hs) begin b_id_q = awid_c; w_idx = 0; end
        if (w_hs) begin
          if (w_idx < BEATS) mem[w_idx] = wdata_c;
          w_idx++;
          if (wlast_c) begin b_pend = 1; b_delay = bp ? int'($urandom_range(0, 3)) : 0; end
        end
        if (b_hs) bus.BVALID = 0;
        if (b_pend) begin
          if (b_delay == 0) begin
            bus.BVALID = 1; bus.BID = b_id_q; bus.BRESP = 2'b00; b_pend = 0;
          end else b_delay--;
        end
        if (ar_hs) begin r_act = 1; r_idx = 0; r_id_q = arid_c; end
        if (r_hs) begin
          bus.RVALID = 0; r_idx++;
          if (r_idx >= BEATS) r_act = 0;
        end
        if (r_act && !bus.RVALID && (!bp || $urandom_range(0, 1) == 1)) begin
          bus.RVALID = 1;
          bus.RID    = r_id_q;
          bus.RDATA  = mem[r_idx] ^ (corrupt_mask[r_idx] ? 32'h00FF_0000 : 32'h0);
          bus.RRESP  = rerr_mask[r_idx] ? 2'b10 : 2'b00;
          bus.RLAST  = (r_idx == BEATS - 1);
        end
        bus.AWREADY = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
        bus.WREADY  = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
        bus.ARREADY = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
    end
  end

  // Push what one complete test must produce, derived from the pattern rule k ^ seed.
  task automatic expect_run(input logic [DW-1:0] s, input logic [7:0] cm, input logic [7:0] em,
                            output logic [4:0] res);
    int nerr = 0;
    for (int k = 0; k < BEATS; k++) begin
      exp_w.push_back({(k == BEATS - 1), DW'(k) ^ s});
      if (cm[k] || em[k]) nerr++;
    end
    if (nerr > 15) nerr = 15;
    res = {(nerr != 0), 4'(nerr)};
    exp_awid.push_back(next_id);
    exp_arid.push_back(next_id);
    exp_res.push_back(res);
    next_id = next_id + 1'b1;
  endtask

  task automatic run(input logic [DW-1:0] s, input bit b, input logic [7:0] cm,
                     input logic [7:0] em, input bit poke);
    logic [4:0] res;
    int d0, t;
    bp = b; corrupt_mask = cm; rerr_mask = em;
    expect_run(s, cm, em, res);
    d0 = done_cnt;
    seed = s; start = 1;
    @(posedge clk); #1;
    start = 0; seed = $urandom;
    @(negedge clk);
    check("aw_cycle1", bus.AWVALID, 1'b1);
    if (poke) begin
      t = 0;
      while (!bus.WVALID && t < 200) begin @(posedge clk); #1; t++; end
      seed = 32'hDEAD_BEEF; start = 1;
      @(posedge clk); #1;
      start = 0;
    end
    t = 0;
    while (done_cnt == d0 && t < 2000) begin @(posedge clk); #1; t++; end
    check("done_seen", (done_cnt != d0), 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_after", {busy, bus.AWVALID, bus.WVALID, bus.ARVALID}, 4'b0);
    check("result_held", {error, err_cnt}, res);
    check("w_drained", exp_w.size(), 0);
  endtask

  initial begin
    logic [4:0] res;
    int t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {bus.AWVALID, bus.WVALID, bus.WLAST, bus.BREADY, bus.ARVALID,
                       bus.RREADY, busy, done, error}, 9'b0);
    check("rst_cnt_ids", {err_cnt, bus.AWID, bus.ARID}, 8'b0);
    @(posedge clk); #1;
    rst = 0;

    run(32'h0, 0, 8'h00, 8'h00, 0);
    run(32'hA5A5_0000, 0, 8'h00, 8'h00, 0);
    for (int i = 0; i < 3; i++) run($urandom, 1, 8'h00, 8'h00, 0);
    run($urandom, 0, 8'b0010_0100, 8'b0100_0000, 0);
    run($urandom, 1, 8'h00, 8'h00, 1);

    // Abort mid-read: beats 1 and 2 are corrupted, reset lands while beat 4 is presented.
    bp = 0; corrupt_mask = 8'b0000_0110; rerr_mask = 8'h00;
    expect_run(32'h1234_5678, corrupt_mask, rerr_mask, res);
    seed = 32'h1234_5678; start = 1;
    @(posedge clk); #1;
    start = 0;
    t = 0;
    do begin @(negedge clk); t++; end while (!(bus.RVALID && r_idx == 4) && t < 500);
    check("reach_r_beat4", (bus.RVALID && r_idx == 4), 1'b1);
    check("pre_reset_cnt", err_cnt, 4'd2);
    rst = 1;
    exp_w.delete(); exp_awid.delete(); exp_arid.delete(); exp_res.delete();
    next_id = '0;
    @(posedge clk);
    @(negedge clk);
    check("reset_mid_ctrl", {bus.AWVALID, bus.WVALID, bus.ARVALID, bus.BREADY, bus.RREADY,
                             busy, done, error}, 8'b0);
    check("reset_mid_cnt", err_cnt, 4'd0);
    @(posedge clk); #1;
    rst = 0;

    run(32'h0F0F_F0F0, 0, 8'h00, 8'h00, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
